// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the regfile_mp register file.
// Optional write-to-read forwarding is enabled by defining REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

  typedef enum logic {ST_IDLE, ST_SWEEP} clr_state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 32;
  localparam int DEF_NREAD = 2;
  localparam int BUS_MAX   = 256;

  // Extracts field p of width w from a packed bus (right-aligned, zero-filled).
  function automatic logic [BUS_MAX-1:0] field_get(input logic [BUS_MAX-1:0] bus,
                                                   input int p, input int w);
    logic [BUS_MAX-1:0] mask;
    mask = (BUS_MAX'(1) << w) - BUS_MAX'(1);
    return (bus >> (p * w)) & mask;
  endfunction

endpackage

// File: rtl/regfile_mp_clr_fsm.sv
// Bulk-clear sequencer: sweeps every entry once, one per cycle, asserting busy.
// Part of regfile_mp; REGFILE_MP_BYPASS_EN does not affect this block.
module regfile_mp_clr_fsm
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     clr_en,
  output logic [$clog2(DEPTH)-1:0] clr_idx
);

  localparam int AW = $clog2(DEPTH);

  clr_state_e    state, state_nxt;
  logic [AW-1:0] idx, idx_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_IDLE: begin
        if (clr_req) begin
          state_nxt = ST_SWEEP;
          idx_nxt   = '0;
        end
      end
      ST_SWEEP: begin
        // The wrap of idx back to zero coincides with the return to idle.
        idx_nxt = idx + AW'(1);
        if (idx == AW'(DEPTH - 1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy    = (state == ST_SWEEP);
  assign clr_en  = busy;
  assign clr_idx = idx;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with registered reads and a bulk-clear sweep.
// Define REGFILE_MP_BYPASS_EN to forward same-edge write data to matching read ports.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NREAD   = DEF_NREAD,
  parameter int ZERO_R0 = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NREAD*$clog2(DEPTH)-1:0]   rd_addr,
  output logic [NREAD*WIDTH-1:0]           rd_data,
  input  logic                             wr_en,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr,
  input  logic [WIDTH-1:0]                 wr_data,
  input  logic                             clr_req,
  output logic                             busy,
  output logic                             wr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem     [DEPTH];
  logic [AW-1:0]    rd_idx  [NREAD];
  logic [WIDTH-1:0] rd_next [NREAD];
  logic             clr_en;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;

  regfile_mp_clr_fsm #(.DEPTH(DEPTH)) u_clr_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_en  (clr_en),
    .clr_idx (clr_idx)
  );

  // Writes to the hardwired-zero entry are dropped quietly; only busy raises wr_err.
  assign wr_ok = wr_en && !busy && !((ZERO_R0 != 0) && (wr_addr == '0));

  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      rd_idx[p]  = AW'(field_get(BUS_MAX'(rd_addr), p, AW));
      rd_next[p] = mem[rd_idx[p]];
`ifdef REGFILE_MP_BYPASS_EN
      if (wr_ok && (wr_addr == rd_idx[p])) rd_next[p] = wr_data;
`endif
      if ((ZERO_R0 != 0) && (rd_idx[p] == '0)) rd_next[p] = '0;
    end
  end

  // NOTE: the array is built from flops, so it is reset explicitly; a RAM macro could not be.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      for (int p = 0; p < NREAD; p++) rd_data[p*WIDTH +: WIDTH] <= rd_next[p];
      wr_err <= wr_en && busy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32x32/2-port and an 8x16/4-port instance against an array model.
// Build with REGFILE_MP_BYPASS_EN defined to check the forwarding variant.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic             sel;
    logic [3:0][31:0] rd;
    logic             busy;
    logic             wr_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [9:0]  a_rd_addr = '0;
  logic [63:0] a_rd_data;
  logic        a_wr_en = 1'b0;
  logic [4:0]  a_wr_addr = '0;
  logic [31:0] a_wr_data = '0;
  logic        a_clr_req = 1'b0;
  logic        a_busy, a_wr_err;

  logic [11:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic        b_wr_en = 1'b0;
  logic [2:0]  b_wr_addr = '0;
  logic [15:0] b_wr_data = '0;
  logic        b_clr_req = 1'b0;
  logic        b_busy, b_wr_err;

  regfile_mp u_dut (
    .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .clr_req(a_clr_req), .busy(a_busy), .wr_err(a_wr_err)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(8), .NREAD(4), .ZERO_R0(1)) u_small (
    .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .clr_req(b_clr_req), .busy(b_busy), .wr_err(b_wr_err)
  );

  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  // Reference model: plain arrays plus "clear in progress" bookkeeping per instance.
  logic [31:0] mdl [2][32];
  bit          m_busy [2];
  int          m_pos  [2];

  // Stimulus for the next cycle.
  int          ra [4];
  bit          we, cr;
  int          wa;
  logic [31:0] wd;

  function automatic int depth_of(input bit s);
    return s ? 8 : 32;
  endfunction

  function automatic int nread_of(input bit s);
    return s ? 4 : 2;
  endfunction

  function automatic logic [31:0] mask_of(input bit s);
    return s ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 32; i++) mdl[s][i] = '0;
      m_busy[s] = 1'b0;
      m_pos[s]  = 0;
    end
  endtask

  // Drive one cycle on instance s and push what its outputs must be after the next edge.
  task automatic step(input bit s);
    exp_t e;
    int   d, a, w;
    logic [31:0] data;
    d    = depth_of(s);
    w    = wa % d;
    data = wd & mask_of(s);
    @(negedge clk);
    rst = 1'b0;
    if (!s) begin
      a_rd_addr = {5'(ra[1] % d), 5'(ra[0] % d)};
      a_wr_en = we; a_wr_addr = 5'(w); a_wr_data = data; a_clr_req = cr;
      b_wr_en = 1'b0; b_clr_req = 1'b0;
    end else begin
      b_rd_addr = {3'(ra[3] % d), 3'(ra[2] % d), 3'(ra[1] % d), 3'(ra[0] % d)};
      b_wr_en = we; b_wr_addr = 3'(w); b_wr_data = 16'(data); b_clr_req = cr;
      a_wr_en = 1'b0; a_clr_req = 1'b0;
    end
    e = '0;
    e.sel = s;
    for (int p = 0; p < nread_of(s); p++) begin
      a = ra[p] % d;
      if (a == 0)                                e.rd[p] = '0;
      else if (BYP && we && !m_busy[s] && w == a) e.rd[p] = data;
      else                                       e.rd[p] = mdl[s][a];
    end
    e.wr_err = we && m_busy[s];
    if (m_busy[s]) begin
      mdl[s][m_pos[s]] = '0;
      m_pos[s]++;
      if (m_pos[s] == d) m_busy[s] = 1'b0;
    end else begin
      if (we && w != 0) mdl[s][w] = data;
      if (cr) begin
        m_busy[s] = 1'b1;
        m_pos[s]  = 0;
      end
    end
    e.busy = m_busy[s];
    sb_q.push_back(e);
    we = 1'b0;
    cr = 1'b0;
  endtask

  task automatic do_reset(input bit s);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    a_wr_en = 1'b0; a_clr_req = 1'b0; b_wr_en = 1'b0; b_clr_req = 1'b0;
    #1;
    check("busy_async_rst_a", 32'(a_busy), 32'd0);
    check("busy_async_rst_b", 32'(b_busy), 32'd0);
    check("rd_async_rst_a", a_rd_data[31:0], 32'd0);
    model_clear();
    e = '0;
    e.sel = s;
    sb_q.push_back(e);
  endtask

  task automatic wr(input bit s, input int addr, input logic [31:0] data);
    we = 1'b1; wa = addr; wd = data;
    step(s);
  endtask

  task automatic rd(input bit s, input int a0, input int a1, input int a2, input int a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
    step(s);
  endtask

  task automatic rand_run(input bit s, input int n);
    for (int k = 0; k < n; k++) begin
      for (int p = 0; p < 4; p++) ra[p] = $urandom_range(0, depth_of(s) - 1);
      we = ($urandom_range(0, 1) == 1);
      wa = $urandom_range(0, depth_of(s) - 1);
      wd = $urandom;
      cr = ($urandom_range(0, 39) == 0);
      step(s);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare whenever an expectation is queued.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int p = 0; p < nread_of(e.sel); p++) begin
          act = e.sel ? 32'(b_rd_data[p*16 +: 16]) : a_rd_data[p*32 +: 32];
          check($sformatf("rd_data%0d_%s", p, e.sel ? "small" : "main"), act, e.rd[p]);
        end
        check(e.sel ? "busy_small" : "busy_main", 32'(e.sel ? b_busy : a_busy), 32'(e.busy));
        check(e.sel ? "wr_err_small" : "wr_err_main", 32'(e.sel ? b_wr_err : a_wr_err),
              32'(e.wr_err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb_q.size());
    $fatal(1);
  end

  initial begin
    for (int p = 0; p < 4; p++) ra[p] = 0;
    we = 1'b0; cr = 1'b0; wa = 0; wd = '0;
    model_clear();
    repeat (3) @(negedge clk);

    // Reset state: every address reads zero on both ports.
    for (int i = 0; i < 32; i++) rd(0, i, 31 - i, 0, 0);

    // Basic write/read, hardwired zero entry.
    wr(0, 5, 32'hDEAD_BEEF);
    rd(0, 5, 5, 0, 0);
    wr(0, 0, 32'h0000_1234);
    rd(0, 0, 0, 0, 0);

    // Same-edge write and read of one address.
    wr(0, 7, 32'h0000_0011);
    ra[0] = 7; ra[1] = 5;
    wr(0, 7, 32'hA5A5_A5A5);
    rd(0, 7, 7, 0, 0);

    rand_run(0, 300);
    while (m_busy[0]) rand_run(0, 1);

    // Fill, clear, write on busy cycle 3, then read everything back.
    for (int i = 1; i < 32; i++) wr(0, i, 32'(i));
    cr = 1'b1;
    rd(0, 3, 4, 0, 0);
    for (int j = 1; j <= 34; j++) begin
      if (j == 3) begin
        we = 1'b1; wa = 9; wd = 32'h0000_0BAD;
      end
      rd(0, $urandom_range(0, 31), $urandom_range(0, 31), 0, 0);
    end
    for (int i = 0; i < 32; i++) rd(0, i, (i + 1) % 32, 0, 0);

    // Reset in the middle of a sweep.
    for (int i = 1; i < 32; i++) wr(0, i, 32'hF000_0000 + 32'(i));
    cr = 1'b1;
    rd(0, 1, 2, 0, 0);
    for (int j = 1; j < 10; j++) rd(0, 20 + j, j, 0, 0);
    do_reset(0);
    for (int i = 0; i < 32; i++) rd(0, i, 31 - i, 0, 0);
    wr(0, 3, 32'h0000_CAFE);
    rd(0, 3, 3, 0, 0);

    // Small instance: 8 entries, 4 read ports, 16-bit data.
    for (int i = 0; i < 8; i++) wr(1, i, 32'h1000 + 32'(i) * 32'h111);
    rd(1, 1, 3, 5, 7);
    rd(1, 6, 4, 2, 0);
    cr = 1'b1;
    rd(1, 1, 2, 3, 4);
    for (int j = 0; j < 10; j++) rd(1, j % 8, (j + 3) % 8, (j + 5) % 8, 7);
    rand_run(1, 200);
    while (m_busy[1]) rand_run(1, 1);
    rand_run(0, 100);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file. It is the next-generation replacement for the fixed 32x32, 2-read/1-write register file in the datapath. It adds configurable width, depth and read-port count, an optional hardwired-zero entry 0, and a sequenced bulk-clear engine with a busy handshake. Reads are registered: data is sampled on the clock edge, as in the current datapath timing.

Parameters:
- WIDTH, 32, data bits per entry
- DEPTH, 32, number of entries; must be a power of two, >=2
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NREAD, 2, number of read ports, 1..4
- ZERO_R0, 1, 1 = entry 0 always reads zero and ignores writes

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NREAD*AW  packed read addresses; port p uses bits [p*AW +: AW]
- rd_data  out  NREAD*WIDTH  packed registered read data; port p uses bits [p*WIDTH +: WIDTH]
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- clr_req  in  1  single-cycle request to clear all entries
- busy  out  1  high while the clear sweep is running
- wr_err  out  1  one-cycle pulse: a write was dropped because busy was high

Behaviour:
- Reset (async, on rst high): all entries = 0, rd_data = 0, busy = 0, wr_err = 0, FSM = IDLE, sweep index = 0. Reset mid-sweep aborts the sweep immediately; no resumption.
- Read latency: 1 cycle. On posedge clk, rd_data[p] <= mem[rd_addr[p]] for every p, independent of wr_en and busy.
- If ZERO_R0 = 1 and rd_addr[p] == 0, rd_data[p] <= 0.
- Write: on posedge clk, when wr_en && !busy, mem[wr_addr] <= wr_data.
  - Writes to entry 0 with ZERO_R0 = 1 are silently discarded; wr_err is not raised.
- Same-cycle read and write to the same address (no bypass): the read returns the old value.
- Write while busy: the write is discarded and wr_err = 1 on the following cycle. wr_err is otherwise 0.
- Clear FSM, two states:
  - IDLE: clr_req = 1 -> SWEEP, idx <= 0, busy <= 1.
  - SWEEP: each cycle mem[idx] <= 0 and idx <= idx + 1. When idx == DEPTH-1: -> IDLE, busy <= 0.
  - busy is high for exactly DEPTH cycles, starting the cycle after clr_req.
  - clr_req while in SWEEP is ignored.
- clr_req and wr_en in the same IDLE cycle: the write commits, then the sweep later zeroes it.
- During SWEEP, reads return current contents: already-swept entries read 0, others read the old value.
- idx is AW bits wide. The wrap from DEPTH-1 to 0 is the termination point, not an overflow.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-to-read forwarding. If wr_en && !busy && wr_addr == rd_addr[p] (and not the zero entry under ZERO_R0), then rd_data[p] <= wr_data in that same edge. Forwarding applies per port independently.
- Undefined: reads return the pre-write value, as stated above.

Decomposition:
- Package regfile_mp_pkg holds:
  - the FSM state enum (ST_IDLE, ST_SWEEP);
  - default WIDTH/DEPTH/NREAD localparams;
  - a function that extracts field p from a packed bus.
- Sub-module regfile_mp_clr_fsm holds the state, idx counter, busy generation and the mem-clear enable/index outputs.
- Storage, read ports, write decode and bypass stay in regfile_mp.

Test Plan:
- Reset, then read all addresses on both ports -> rd_data = 0 one cycle after each address is applied; busy = 0, wr_err = 0.
- Write 0xDEADBEEF to addr 5, next cycle rd_addr0 = 5, rd_addr1 = 5 -> both ports read 0xDEADBEEF one cycle later. Write 0x1234 to addr 0 (ZERO_R0 = 1) -> addr 0 reads 0.
- Same-cycle write 0xA5A5A5A5 to addr 7 with rd_addr0 = 7 (old value 0x11) -> rd_data0 = 0x11 without REGFILE_MP_BYPASS_EN, 0xA5A5A5A5 with it.
- Fill entries 1..31 with their index, pulse clr_req:
  - busy high exactly 32 cycles;
  - a write issued on busy cycle 3 is dropped and wr_err pulses once;
  - after busy falls, every entry reads 0.
- Assert rst on sweep cycle 10 -> busy = 0 immediately, all entries 0. A write after reset release commits normally.
- DEPTH = 8, NREAD = 4, WIDTH = 16: write distinct values to 8 entries, then read 4 different addresses simultaneously -> all 4 correct after 1 cycle. Clear sweep lasts 8 cycles.
